// File: rtl/arbitro_mux_3in.sv
// arbitro_mux_3in: round-robin owner of the shared 3-input mux (Req/Last per A,B,C in bits 2,1,0; Gnt one-hot, Sel drives the mux, Valido beat present, Ocupado path granted)
module arbitro_mux_3in #(
  parameter int MAX_BEATS = 8,
  parameter int CW = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] Req,
  input  logic [2:0] Last,
  input  logic       Listo,
  output logic [2:0] Gnt,
  output logic [1:0] Sel,
  output logic       Valido,
  output logic       Ocupado
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state_q, state_d;
  logic [2:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d, ptr_q, ptr_d, n1, n2, pick;
  logic [CW-1:0] cnt_q, cnt_d;
  logic go, acc, rel;
  always_comb begin
    n1 = ptr_q == 2'd0 ? 2'd2 : ptr_q - 2'd1;
    n2 = n1 == 2'd0 ? 2'd2 : n1 - 2'd1;
    pick = Req[n1] ? n1 : Req[n2] ? n2 : ptr_q;
    go = state_q == IDLE && |Req;
    Valido = state_q == GRANT && Req[sel_q];
    acc = Valido && Listo;
    rel = state_q == GRANT && (!Req[sel_q] || (acc && (Last[sel_q] || cnt_q == CW'(MAX_BEATS - 1))));
    state_d = go ? GRANT : rel ? IDLE : state_q;
    gnt_d = go ? 3'b001 << pick : rel ? 3'b000 : gnt_q;
    sel_d = go ? pick : sel_q;
    ptr_d = rel ? sel_q : ptr_q;
    cnt_d = go ? '0 : acc ? cnt_q + CW'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q <= '0;
      sel_q <= '0;
      ptr_q <= 2'd0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      sel_q <= sel_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  assign Gnt = gnt_q;
  assign Sel = sel_q;
  assign Ocupado = state_q == GRANT;
endmodule

// File: tb/tb_arbitro_mux_3in.sv
// tb_arbitro_mux_3in: directed and random stimulus against a queue-fed reference model of the arbiter
module tb_arbitro_mux_3in;
  localparam int MB = 8;
  logic clk = 0, reset_n = 0, Listo = 0;
  logic [2:0] Req = 0, Last = 0, Gnt;
  logic [1:0] Sel;
  logic Valido, Ocupado;
  int tests = 0, fails = 0, ncyc = 0;
  logic [7:0] q[$];
  int owner = -1, prev = 2, beats = 0;
  logic [1:0] msel = 0;
  arbitro_mux_3in #(.MAX_BEATS(MB), .CW(4)) dut (
    .clk(clk), .reset_n(reset_n), .Req(Req), .Last(Last), .Listo(Listo),
    .Gnt(Gnt), .Sel(Sel), .Valido(Valido), .Ocupado(Ocupado)
  );
  always #5 clk = ~clk;
  task automatic model_reset();
    owner = -1;
    prev = 2;
    beats = 0;
    msel = 0;
  endtask
  task automatic model_edge();
    if (!reset_n) model_reset();
    else if (owner < 0) begin
      for (int k = 1; k <= 3; k++) begin
        int c;
        c = (prev + k) % 3;
        if (owner < 0 && Req[2-c]) owner = c;
      end
      if (owner >= 0) begin
        beats = 0;
        msel = 2'(2 - owner);
      end
    end else if (!Req[2-owner]) begin
      prev = owner;
      owner = -1;
    end else if (Listo) begin
      beats++;
      if (Last[2-owner] || beats == MB) begin
        prev = owner;
        owner = -1;
      end
    end
  endtask
  function automatic logic [7:0] expected();
    logic [2:0] g;
    g = owner >= 0 ? 3'(1 << (2 - owner)) : 3'b000;
    return {g, msel, 1'(owner >= 0 && Req[2-owner]), 1'(owner >= 0), 1'b0};
  endfunction
  task automatic cyc(input logic [2:0] r, input logic [2:0] l, input logic li, input logic rn);
    @(posedge clk);
    #1;
    model_edge();
    reset_n = rn;
    Req = r;
    Last = l;
    Listo = li;
    if (!reset_n) model_reset();
    q.push_back(expected());
  endtask
  always @(negedge clk) begin
    ncyc++;
    if (q.size() > 0) begin
      logic [7:0] e, g;
      e = q.pop_front();
      g = {Gnt, Sel, Valido, Ocupado, 1'b0};
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL outputs cycle %0d: Gnt=%b Sel=%0d Valido=%b Ocupado=%b, required Gnt=%b Sel=%0d Valido=%b Ocupado=%b",
                 ncyc, g[7:5], g[4:3], g[2], g[1], e[7:5], e[4:3], e[2], e[1]);
      end
    end
  end
  initial begin
    cyc(3'b000, 3'b000, 1, 0);
    cyc(3'b000, 3'b000, 1, 1);
    cyc(3'b001, 3'b000, 1, 1);
    cyc(3'b001, 3'b000, 1, 1);
    cyc(3'b001, 3'b000, 1, 1);
    cyc(3'b001, 3'b001, 1, 1);
    cyc(3'b000, 3'b000, 1, 1);
    cyc(3'b000, 3'b000, 1, 1);
    for (int i = 0; i < 16; i++) cyc(3'b111, (i % 3 == 2) ? 3'b111 : 3'b000, 1, 1);
    cyc(3'b000, 3'b000, 1, 0);
    for (int i = 0; i < 24; i++) cyc(3'b110, 3'b000, 1, 1);
    cyc(3'b000, 3'b000, 1, 1);
    cyc(3'b010, 3'b000, 1, 1);
    cyc(3'b010, 3'b000, 1, 1);
    cyc(3'b010, 3'b000, 0, 1);
    cyc(3'b010, 3'b000, 0, 1);
    cyc(3'b010, 3'b000, 1, 1);
    cyc(3'b010, 3'b010, 1, 1);
    cyc(3'b000, 3'b000, 1, 1);
    cyc(3'b001, 3'b000, 1, 1);
    cyc(3'b001, 3'b000, 1, 1);
    cyc(3'b101, 3'b000, 1, 1);
    cyc(3'b100, 3'b000, 1, 1);
    for (int i = 0; i < 6; i++) cyc(3'b111, 3'b000, 0, 1);
    cyc(3'b100, 3'b000, 1, 1);
    cyc(3'b100, 3'b000, 1, 1);
    cyc(3'b100, 3'b000, 1, 0);
    cyc(3'b111, 3'b000, 1, 1);
    for (int i = 0; i < 6; i++) cyc(3'b111, 3'b111, 1, 1);
    for (int i = 0; i < 2000; i++)
      cyc(3'($urandom), ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000,
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 299) != 0));
    @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/arbitro_mux_3in.md
# arbitro_mux_3in

Round-robin arbiter that shares the 3-input datapath multiplexer (`Mux_3in_1out`) between three requesters A, B and C. Each requester asks for the shared path with a request line. The block grants one owner at a time and drives the mux select. It then counts data beats accepted by the downstream stage and releases the path on end-of-packet, on beat limit, or on request withdrawal. It sits between the requesters and the mux, and its `Sel` output drives the mux `Sel` input directly.

## Interface
- `MAX_BEATS`, 8: maximum beats per grant. Legal range 1..2^`CW`.
- `CW`, 4: beat-counter width.

- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `Req`  in  3  requests. Bit 2 = A, bit 1 = B, bit 0 = C.
- `Last`  in  3  end-of-packet flag per requester, same bit order. Sampled only for the current owner.
- `Listo`  in  1  downstream ready. A beat is accepted when `Valido & Listo`.
- `Gnt`  out  3  one-hot grant, same bit order. All zeros when no owner.
- `Sel`  out  2  mux select, using the mux encoding: A = 2, B = 1, C = 0. The value 3 is never driven.
- `Valido`  out  1  the current owner presents a beat.
- `Ocupado`  out  1  the path is granted (state GRANT).

## Operation
- Reset value of the single clock and reset is fixed: one clock `clk`; `reset_n` is asynchronous, active-low.
- Reset values:
  - state = IDLE
  - `Gnt` = 0
  - `Sel` = 0
  - `Valido` = 0
  - `Ocupado` = 0
  - beat counter = 0
  - last-owner pointer = C, so the first priority order is A, B, C.
- State IDLE:
  - If any `Req` bit is high, pick the first requester in round-robin order that starts after the last owner. Order is A→B→C→A.
  - Register that owner into `Gnt`/`Sel`, clear the counter, and go to GRANT.
  - If no `Req` bit is high, stay in IDLE. `Sel` holds its last value so the mux never sees an undefined select.
- State GRANT:
  - `Valido` = `Req[owner]`, combinational from the registered owner.
  - On each accepted beat, the counter increments.
- Release from GRANT to IDLE, at the clock edge where any of these holds:
  - (a) a beat is accepted and `Last[owner]` = 1;
  - (b) a beat is accepted and counter = `MAX_BEATS`−1;
  - (c) `Req[owner]` = 0 (abort; no beat is accepted that cycle).
- On release:
  - `Gnt` clears to 0.
  - The pointer is set to the releasing owner.
  - `Sel` holds its value.
- `Req` or `Last` on non-owner bits has no effect during GRANT.
- `Ocupado` = 1 exactly while in state GRANT.

## Timing
- Grant latency: `Req` high at edge n while in IDLE → `Gnt`/`Sel`/`Ocupado` valid after edge n. `Valido` can be high in the cycle following edge n.
- Between consecutive owners there is exactly one IDLE cycle. `Gnt` is zero in that cycle, even when other requests are pending.
- `Sel` changes only on the edge that enters GRANT. It is stable for the whole grant and for the following IDLE cycle.
- `Listo` low stalls the transfer. The counter does not advance and the owner holds the grant indefinitely while `Req[owner]` stays high.
- Limit and `Last` on the same beat: release occurs once, with identical behaviour to either condition alone.
- `MAX_BEATS` = 1: every grant releases after its first accepted beat.
- `reset_n` asserted mid-grant: all outputs return to their reset values immediately (asynchronous), and the pointer returns to C. No partial-packet state survives.
- Requests may change at any cycle. The arbitration decision uses only `Req` as sampled at the IDLE-cycle edge.

## Test plan
- Reset and single grant: release `reset_n`, then assert `Req`=3'b001 with `Listo`=1 and `Last[0]` on the 3rd beat.
  - Required: `Gnt`=001 and `Sel`=0 one edge later.
  - Required: exactly 3 beats with `Valido`=1, then `Gnt`=000 and `Ocupado`=0.
- Round-robin fairness: hold `Req`=3'b111, with each packet 2 beats (`Last` on beat 2) and `Listo`=1.
  - Required: grant sequence A, B, C, A… with `Sel` 2, 1, 0, 2.
  - Required: one `Gnt`=000 cycle between owners.
- Beat limit: with `MAX_BEATS`=8, A requests and never asserts `Last`.
  - Required: release after the 8th accepted beat.
  - Required: if B is also requesting, B is granted after one IDLE cycle.
- Back-pressure: owner B, with `Listo` toggled 1, 0, 0, 1, 1 and `Last` on the 3rd accepted beat.
  - Required: the counter advances only in `Listo`=1 cycles.
  - Required: release happens on the 5th cycle.
- Abort: owner C drops `Req[0]` after 1 beat while A is requesting.
  - Required: `Gnt` clears at that edge with no beat accepted.
  - Required: A is granted after one IDLE cycle, and the next priority order starts at A.
- Async reset mid-grant: assert `reset_n`=0 between clock edges during an A grant.
  - Required: `Gnt`, `Sel`, `Valido` and `Ocupado` are 0 immediately.
  - Required: after `reset_n` is released, with `Req`=111, A is granted first.
